// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA pipeline: default 800x600@60 timing, count width,
// and the per-axis total helper used by both the timing source and the draw chain.
package vga_timing_pkg;

   localparam int unsigned CNT_W     = 11;
   localparam int unsigned MAX_TOTAL = 2048;

   localparam int unsigned H_ACTIVE_DEF = 800;
   localparam int unsigned H_FP_DEF     = 40;
   localparam int unsigned H_SYNC_DEF   = 128;
   localparam int unsigned H_BP_DEF     = 88;

   localparam int unsigned V_ACTIVE_DEF = 600;
   localparam int unsigned V_FP_DEF     = 1;
   localparam int unsigned V_SYNC_DEF   = 4;
   localparam int unsigned V_BP_DEF     = 23;

   function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping counter with sync and blank flags registered from the next count,
// so flags always describe the count presented in the same cycle.
module vga_axis_cnt
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned FP     = H_FP_DEF,
   parameter int unsigned SYNC   = H_SYNC_DEF,
   parameter int unsigned BP     = H_BP_DEF,
   parameter bit          POL    = 1'b1
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             step,
   output logic             wrap_out,
   output logic [CNT_W-1:0] count,
   output logic             sync,
   output logic             blnk
);

   localparam int unsigned      TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam int unsigned      SYNC_START = ACTIVE + FP;
   localparam int unsigned      SYNC_STOP  = ACTIVE + FP + SYNC;
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);

   if (TOTAL > MAX_TOTAL) begin : g_total_check
      $error("vga_axis_cnt: total %0d exceeds %0d", TOTAL, MAX_TOTAL);
   end

   logic [CNT_W-1:0] count_d;
   int unsigned      nxt;

   assign wrap_out = step && (count == LAST);

   always_comb begin
      count_d = count;
      if (step) begin
         count_d = wrap_out ? '0 : count + 1'b1;
      end
   end

   assign nxt = 32'(count_d);

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         sync  <= ~POL;
         blnk  <= 1'b0;
      end else begin
         count <= count_d;
         sync  <= (nxt >= SYNC_START && nxt < SYNC_STOP) ? POL : ~POL;
         blnk  <= (nxt >= ACTIVE);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: horizontal and vertical axis counters plus a registered frame-start
// tick that coincides with the counts showing (0,0) after a wrap.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
   parameter int unsigned H_FP      = H_FP_DEF,
   parameter int unsigned H_SYNC    = H_SYNC_DEF,
   parameter int unsigned H_BP      = H_BP_DEF,
   parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
   parameter int unsigned V_FP      = V_FP_DEF,
   parameter int unsigned V_SYNC    = V_SYNC_DEF,
   parameter int unsigned V_BP      = V_BP_DEF,
   parameter bit          HSYNC_POL = 1'b1,
   parameter bit          VSYNC_POL = 1'b1
) (
   input  logic             pclk,
   input  logic             rst,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hsync,
   output logic             vsync,
   output logic             hblnk,
   output logic             vblnk,
   output logic             frame_tick
);

   logic h_wrap;
   logic v_wrap;

   vga_axis_cnt #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .POL    (HSYNC_POL)
   ) u_h_axis (
      .pclk     (pclk),
      .rst      (rst),
      .step     (1'b1),
      .wrap_out (h_wrap),
      .count    (hcount),
      .sync     (hsync),
      .blnk     (hblnk)
   );

   vga_axis_cnt #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .POL    (VSYNC_POL)
   ) u_v_axis (
      .pclk     (pclk),
      .rst      (rst),
      .step     (h_wrap),
      .wrap_out (v_wrap),
      .count    (vcount),
      .sync     (vsync),
      .blnk     (vblnk)
   );

   // v_wrap already implies the horizontal wrap, so it marks the last pixel of the frame.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus two small-raster instances (active-high
// and active-low sync) checked each cycle against a cycles-since-reset raster model.
module tb_vga_timing_gen;

   logic pclk = 1'b0;
   logic rst  = 1'b0;

   int checks = 0;
   int errors = 0;
   int n      = 0;

   logic [10:0] d_hc, d_vc, s_hc, s_vc, g_hc, g_vc;
   logic        d_hs, d_vs, d_hb, d_vb, d_ft;
   logic        s_hs, s_vs, s_hb, s_vb, s_ft;
   logic        g_hs, g_vs, g_hb, g_vb, g_ft;

   always #5 pclk = ~pclk;

   vga_timing_gen u_def (
      .pclk (pclk), .rst (rst), .hcount (d_hc), .vcount (d_vc), .hsync (d_hs), .vsync (d_vs),
      .hblnk (d_hb), .vblnk (d_vb), .frame_tick (d_ft)
   );

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_ACTIVE (12), .V_FP (1), .V_SYNC (3), .V_BP (2)
   ) u_sml (
      .pclk (pclk), .rst (rst), .hcount (s_hc), .vcount (s_vc), .hsync (s_hs), .vsync (s_vs),
      .hblnk (s_hb), .vblnk (s_vb), .frame_tick (s_ft)
   );

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
      .V_ACTIVE (12), .V_FP (1), .V_SYNC (3), .V_BP (2),
      .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
   ) u_neg (
      .pclk (pclk), .rst (rst), .hcount (g_hc), .vcount (g_vc), .hsync (g_hs), .vsync (g_vs),
      .hblnk (g_hb), .vblnk (g_vb), .frame_tick (g_ft)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at n=%0d t=%0t: got %0d required %0d", name, n, $time, act, exp);
      end
   endtask

   // Raster position follows directly from pixel clocks elapsed since reset release.
   task automatic model_cmp(input string tag, input int ha, input int hf, input int hs,
                            input int hb, input int va, input int vf, input int vs, input int vb,
                            input int hp, input int vp, input logic [10:0] hc,
                            input logic [10:0] vc, input logic hsy, input logic vsy,
                            input logic hbl, input logic vbl, input logic ft);
      int ht, vt, h, v;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      h  = n % ht;
      v  = (n / ht) % vt;
      chk({tag, ".hcount"}, int'(hc), h);
      chk({tag, ".vcount"}, int'(vc), v);
      chk({tag, ".hsync"}, int'(hsy), (h >= ha + hf && h < ha + hf + hs) ? hp : 1 - hp);
      chk({tag, ".vsync"}, int'(vsy), (v >= va + vf && v < va + vf + vs) ? vp : 1 - vp);
      chk({tag, ".hblnk"}, int'(hbl), (h >= ha) ? 1 : 0);
      chk({tag, ".vblnk"}, int'(vbl), (v >= va) ? 1 : 0);
      chk({tag, ".frame_tick"}, int'(ft), (n != 0 && n % (ht * vt) == 0) ? 1 : 0);
   endtask

   always @(posedge pclk or negedge rst) begin
      if (!rst) n <= 0;
      else      n <= n + 1;
   end

   always @(negedge pclk) begin
      model_cmp("def", 800, 40, 128, 88, 600, 1, 4, 23, 1, 1,
                d_hc, d_vc, d_hs, d_vs, d_hb, d_vb, d_ft);
      model_cmp("sml", 16, 4, 8, 4, 12, 1, 3, 2, 1, 1,
                s_hc, s_vc, s_hs, s_vs, s_hb, s_vb, s_ft);
      model_cmp("neg", 16, 4, 8, 4, 12, 1, 3, 2, 0, 0,
                g_hc, g_vc, g_hs, g_vs, g_hb, g_vb, g_ft);
   end

   task automatic goto(input int t);
      while (n < t) @(negedge pclk);
   endtask

   task automatic chk_reset_literals(input string tag);
      chk({tag, ".rst.hcount"}, int'(d_hc), 0);
      chk({tag, ".rst.vcount"}, int'(d_vc), 0);
      chk({tag, ".rst.hblnk"}, int'(d_hb), 0);
      chk({tag, ".rst.vblnk"}, int'(d_vb), 0);
      chk({tag, ".rst.hsync"}, int'(d_hs), 0);
      chk({tag, ".rst.vsync"}, int'(d_vs), 0);
      chk({tag, ".rst.frame_tick"}, int'(d_ft), 0);
      chk({tag, ".rst.neg_hsync"}, int'(g_hs), 1);
      chk({tag, ".rst.neg_vsync"}, int'(g_vs), 1);
      chk({tag, ".rst.neg_hblnk"}, int'(g_hb), 0);
   endtask

   initial begin
      int gap, hcnt, svcnt, shcnt, gvlow;
      rst = 1'b0;
      repeat (5) @(posedge pclk);
      @(negedge pclk);
      chk_reset_literals("init");
      rst = 1'b1;
      @(negedge pclk);
      chk("first_edge.hcount", int'(d_hc), 1);
      chk("first_edge.vcount", int'(d_vc), 0);

      // Small raster: 32 pixels x 18 lines, vsync lines 13..15, 576-cycle frame.
      goto(352); chk("sml.line11.vblnk", int'(s_vb), 0);
      goto(384); chk("sml.line12.vblnk", int'(s_vb), 1);
      goto(415); chk("sml.line12.vsync", int'(s_vs), 0);
      goto(416); chk("sml.line13.vsync", int'(s_vs), 1);
                 chk("neg.line13.vsync", int'(g_vs), 0);
      goto(511); chk("sml.line15.vsync", int'(s_vs), 1);
      goto(512); chk("sml.line16.vsync", int'(s_vs), 0);
      goto(575); chk("sml.last.hcount", int'(s_hc), 31);
                 chk("sml.last.vcount", int'(s_vc), 17);
                 chk("sml.last.tick", int'(s_ft), 0);
      goto(576); chk("sml.wrap.hcount", int'(s_hc), 0);
                 chk("sml.wrap.vcount", int'(s_vc), 0);
                 chk("sml.wrap.tick", int'(s_ft), 1);
                 chk("sml.wrap.hblnk", int'(s_hb), 0);
                 chk("sml.wrap.vblnk", int'(s_vb), 0);
      goto(577); chk("sml.after.tick", int'(s_ft), 0);

      // Default raster horizontal boundaries.
      goto(799);  chk("def.799.hblnk", int'(d_hb), 0);
      goto(800);  chk("def.800.hblnk", int'(d_hb), 1);
      goto(839);  chk("def.839.hsync", int'(d_hs), 0);
      goto(840);  chk("def.840.hsync", int'(d_hs), 1);
      goto(967);  chk("def.967.hsync", int'(d_hs), 1);
      goto(968);  chk("def.968.hsync", int'(d_hs), 0);
      goto(1055); chk("def.1055.hcount", int'(d_hc), 1055);
                  chk("def.1055.vcount", int'(d_vc), 0);
      goto(1056); chk("def.wrap.hcount", int'(d_hc), 0);
                  chk("def.wrap.vcount", int'(d_vc), 1);
                  chk("def.wrap.tick", int'(d_ft), 0);

      // Tick-to-tick spacing on the small raster.
      gap = 0;
      while (!s_ft && gap < 2000) begin @(negedge pclk); gap++; end
      chk("sml.tick_found", int'(s_ft), 1);
      gap = 0;
      do begin @(negedge pclk); gap++; end while (!s_ft && gap < 2000);
      chk("sml.tick_period", gap, 576);

      // Mid-frame asynchronous reset at default (500, 2), between clock edges.
      goto(1056 * 2 + 500);
      chk("mid.hcount_before", int'(d_hc), 500);
      #2 rst = 1'b0;
      #1 chk_reset_literals("mid");
      @(negedge pclk);
      @(negedge pclk);
      rst = 1'b1;

      hcnt = 0; svcnt = 0; shcnt = 0; gvlow = 0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge pclk);
         hcnt += int'(d_hs);
         if (n <= 576) begin
            svcnt += int'(s_vs);
            gvlow += int'(!g_vs);
         end
         if (n <= 32) shcnt += int'(s_hs);
      end
      chk("mid.def_hsync_width", hcnt, 128);
      chk("mid.sml_hsync_width", shcnt, 8);
      chk("mid.sml_vsync_cycles", svcnt, 3 * 32);
      chk("mid.neg_vsync_low_cycles", gvlow, 3 * 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the VGA pipeline. Generates the pixel counters, sync pulses and blanking flags consumed by the draw chain (background → rectangle → ball → score overlay), which delays these signals stage by stage and turns them into RGB. Default timing is 800×600 @ 60 Hz on a 40 MHz pixel clock. It also gives game logic a one-cycle frame-start tick.

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- HSYNC_POL, 1, active level of hsync (1 = active-high)
- VSYNC_POL, 1, active level of vsync

Ports:
- pclk  in  1  pixel clock
- rst  in  1  reset; asynchronous assertion, active-low
- hcount  out  11  pixel index in the current line, 0..H_TOTAL-1
- vcount  out  11  line index in the current frame, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level set by HSYNC_POL
- vsync  out  1  vertical sync, level set by VSYNC_POL
- hblnk  out  1  high when hcount ≥ H_ACTIVE
- vblnk  out  1  high when vcount ≥ V_ACTIVE
- frame_tick  out  1  one-cycle pulse on the cycle where counts wrap to (0,0)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 628). Both must be ≤ 2048. Violating this is an elaboration error.
- Horizontal counter:
  - hcount increments every pclk.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - vcount increments only on the cycle hcount wraps.
  - At V_TOTAL-1 (together with an hcount wrap) it wraps to 0.
- hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Default: 840..967.
- vsync is active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]. Default: 601..604. vsync changes on the same cycle as vcount.
- frame_tick is 1 exactly on the cycle the outputs show hcount=0, vcount=0 following a wrap. It is not asserted in the reset state.
- Blank and sync flags describe the count value presented in the same cycle. Downstream stages depend on this alignment.

## Timing
- All outputs are registered. Flags are computed from the next-count value, so they stay aligned with the counts and add no extra latency.
- Reset (rst low), taking effect immediately and asynchronously:
  - hcount=0, vcount=0
  - hblnk=0, vblnk=0, frame_tick=0
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL (inactive)
- First rising pclk edge after rst goes high: hcount=1, vcount=0.
- Reset asserted mid-frame: the outputs above are forced at once. The next frame starts cleanly from (0,0) with no partial sync pulse.
- Simultaneous horizontal and vertical wrap (hcount=H_TOTAL-1, vcount=V_TOTAL-1): the next cycle is (0,0) with frame_tick=1, vblnk=0 and hblnk=0.
- Frame period is H_TOTAL×V_TOTAL cycles (663 168 with defaults). Consecutive frame_tick pulses are exactly that many cycles apart.

## Structure
- Shared package vga_timing_pkg holds:
  - the default 800×600 constants
  - the count width (11)
  - a function computing totals
- The draw modules use the same package for screen limits.
- One sub-module is natural: vga_axis_cnt, parameterised by ACTIVE/FP/SYNC/BP/POL. It has inputs step and wrap_out and outputs count, sync and blnk. It is instantiated twice:
  - horizontal: step = 1
  - vertical: step = horizontal wrap
- The top adds frame_tick and output registration.

## Test plan
- Reset: hold rst low for 5 cycles → hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=0, vsync=0, frame_tick=0. Release → hcount=1 on the first edge.
- Horizontal blanking and sync:
  - hcount 799 → hblnk=0; hcount 800 → hblnk=1.
  - hsync=1 exactly at hcount 840..967.
  - 1055 → 0 wraps with vcount incremented by 1.
- Vertical: vcount 599 → vblnk=0; vcount 600 → vblnk=1; vsync=1 for lines 601..604 only.
- Frame wrap: at (1055,627) the next cycle is (0,0) with frame_tick=1 for exactly one cycle. The next tick comes 663 168 cycles later.
- Mid-frame reset: assert rst at (500,300) → outputs return to reset values immediately. After release, sync pulse widths on the first frame are 128 pixels and 4 lines.
- Polarity parameters: HSYNC_POL=0, VSYNC_POL=0 → hsync and vsync are high at reset and go low only in the windows above. Blanking is unchanged.
